conv_mac_pipe: RTL

Pipelined, parametrised multiply-accumulate engine for sliding-window convolution: the next-generation compute stage that sits between the window shift module and the result store. It accepts one FILTER_SIZE×FILTER_SIZE window per channel per beat over a valid/ready handshake, accumulates across CHANNELS beats, and adds bias, optional ReLU and saturation. It emits one OUT_W result per output pixel at full throughput (one beat per cycle) under back-pressure.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_adder_tree.sv | 18 +
 rtl/conv_mac_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and arithmetic helpers for the convolution datapath
package conv_pkg;
  localparam int SAT_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int taps, input int ch);
    return dw + cw + 1 + clog2(taps * ch);
  endfunction

  function automatic int tap_idx(input int r, input int c, input int fs);
    return r * fs + c;
  endfunction

  function automatic logic [SAT_W-1:0] saturate(input logic [SAT_W-1:0] v, input logic sgn, input int out_w);
    logic signed [SAT_W-1:0] x, hi, lo;
    x  = $signed(v);
    hi = sgn ? (64'sd1 <<< (out_w - 1)) - 64'sd1 : (64'sd1 <<< out_w) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (out_w - 1)) : 64'sd0;
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction
endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: combinational balanced adder tree over N signed W-bit terms
module conv_adder_tree #(
  parameter int N = 9,
  parameter int W = 21
) (
  input  logic [N*W-1:0] terms,
  output logic [W-1:0]   sum
);
  if (N == 1) begin : g_leaf
    assign sum = terms;
  end else begin : g_split
    localparam int L = N / 2;
    logic [W-1:0] lo, hi;
    conv_adder_tree #(.N(L), .W(W)) u_lo (.terms(terms[L*W-1:0]), .sum(lo));
    conv_adder_tree #(.N(N-L), .W(W)) u_hi (.terms(terms[N*W-1:L*W]), .sum(hi));
    assign sum = lo + hi;
  end
endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: 3-stage multiply/sum/accumulate engine with bias, ReLU and saturation
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int FILTER_SIZE = 3,
  parameter int DATA_W      = 8,
  parameter int COEF_W      = 8,
  parameter int CHANNELS    = 1,
  parameter int OUT_W       = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [FILTER_SIZE*FILTER_SIZE*DATA_W-1:0]   window_in,
  input  logic [CHANNELS*FILTER_SIZE*FILTER_SIZE*COEF_W-1:0] filter_flat,
  input  logic [OUT_W-1:0]                            bias,
  input  logic                                        signed_en,
  input  logic                                        relu_en,
  input  logic                                        flush,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [OUT_W-1:0]                            result,
  output logic [(CHANNELS > 1 ? clog2(CHANNELS) : 1)-1:0] chan_idx
);
  localparam int TAPS  = FILTER_SIZE * FILTER_SIZE;
  localparam int KW    = TAPS * COEF_W;
  localparam int P_W   = DATA_W + COEF_W + 1;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS, CHANNELS);
  localparam int FIN_W = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;
  localparam int CH_W  = CHANNELS > 1 ? clog2(CHANNELS) : 1;

  logic              advance, fire, first_in, last_in, mode_sgn, mode_relu;
  logic [CH_W-1:0]   chan;
  logic              sgn_q, relu_q;
  logic [KW-1:0]     kern;
  logic [TAPS*P_W-1:0]   prod, s1_prod;
  logic              s1_v, s1_first, s1_last, s1_sgn, s1_relu;
  logic [OUT_W-1:0]  s1_bias;
  logic [TAPS*ACC_W-1:0] terms;
  logic [ACC_W-1:0]  tree_sum, s2_sum;
  logic              s2_v, s2_first, s2_last, s2_sgn, s2_relu;
  logic [OUT_W-1:0]  s2_bias;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [FIN_W-1:0]  bias_ext, fin, fin_relu;
  logic [OUT_W-1:0]  sat_val;

  // Operands widened by one bit so both modes share one signed multiplier.
  function automatic logic signed [P_W-1:0] mul(input logic [DATA_W-1:0] d, input logic [COEF_W-1:0] k, input logic s);
    logic signed [DATA_W:0] a;
    logic signed [COEF_W:0] b;
    a = $signed({s & d[DATA_W-1], d});
    b = $signed({s & k[COEF_W-1], k});
    return a * b;
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = rst && advance && !flush;
  assign fire      = in_valid && in_ready;
  assign first_in  = chan == '0;
  assign last_in   = chan == CH_W'(CHANNELS - 1);
  assign mode_sgn  = first_in ? signed_en : sgn_q;
  assign mode_relu = first_in ? relu_en : relu_q;
  assign chan_idx  = chan;

  // Pick the kernel slice for the channel currently expected.
  always_comb begin
    kern = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (chan == CH_W'(k)) kern = filter_flat[k*KW +: KW];
  end

  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_col
      localparam int T = tap_idx(r, c, FILTER_SIZE);
      assign prod[T*P_W +: P_W] = mul(window_in[T*DATA_W +: DATA_W], kern[T*COEF_W +: COEF_W], mode_sgn);
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_ext
    assign terms[i*ACC_W +: ACC_W] = ACC_W'($signed(s1_prod[i*P_W +: P_W]));
  end

  conv_adder_tree #(.N(TAPS), .W(ACC_W)) u_tree (.terms(terms), .sum(tree_sum));

  // Final accumulation, bias, ReLU and clamp for the beat leaving stage 2.
  always_comb begin
    acc_nxt  = s2_first ? s2_sum : acc + s2_sum;
    bias_ext = s2_sgn ? FIN_W'($signed(s2_bias)) : FIN_W'(s2_bias);
    fin      = FIN_W'($signed(acc_nxt)) + bias_ext;
    fin_relu = (s2_relu && s2_sgn && fin[FIN_W-1]) ? '0 : fin;
    sat_val  = OUT_W'(saturate(SAT_W'($signed(fin_relu)), s2_sgn, OUT_W));
  end

  // Channel counter and per-pixel mode latch, updated on accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chan   <= '0;
      sgn_q  <= 1'b0;
      relu_q <= 1'b0;
    end else if (flush) begin
      chan <= '0;
    end else if (fire) begin
      chan <= last_in ? '0 : chan + 1'b1;
      if (first_in) begin
        sgn_q  <= signed_en;
        relu_q <= relu_en;
      end
    end
  end

  // MUL and SUM pipeline registers; flush drops every in-flight beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0; s1_prod <= '0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_sgn <= 1'b0; s1_relu <= 1'b0; s1_bias <= '0;
      s2_v <= 1'b0; s2_sum <= '0; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_sgn <= 1'b0; s2_relu <= 1'b0; s2_bias <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (advance) begin
      s1_v <= fire; s1_prod <= prod; s1_first <= first_in; s1_last <= last_in;
      s1_sgn <= mode_sgn; s1_relu <= mode_relu; s1_bias <= bias;
      s2_v <= s1_v; s2_sum <= tree_sum; s2_first <= s1_first; s2_last <= s1_last;
      s2_sgn <= s1_sgn; s2_relu <= s1_relu; s2_bias <= s1_bias;
    end
  end

  // Accumulator and output register; a held result survives flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      acc <= '0;
      if (advance) out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_v && s2_last;
      if (s2_v) acc <= acc_nxt;
      if (s2_v && s2_last) result <= sat_val;
    end
  end
endmodule
